// File: rtl/rng_seq_ctrl_if.sv
// Colour stream between the sequence controller and the colour consumer.
interface rng_seq_ctrl_if #(
  parameter int IDX_WIDTH = 8
);
  logic [1:0]           color;
  logic                 color_valid;
  logic                 color_ready;
  logic [IDX_WIDTH-1:0] color_idx;
  logic                 seq_end;

  modport master (
    output color, color_valid, color_idx, seq_end,
    input  color_ready
  );

  modport slave (
    input  color, color_valid, color_idx, seq_end,
    output color_ready
  );
endinterface

// File: rtl/rng_seq_ctrl.sv
// Colour sequence controller: captures a seed, steps a Galois LFSR one colour
// per accepted beat, and replays the identical sequence from the saved seed.
module rng_seq_ctrl #(
  parameter int                    SEED_WIDTH = 16,
  parameter logic [SEED_WIDTH-1:0] TAPS       = 16'hB400,
  parameter logic [SEED_WIDTH-1:0] ZERO_SEED  = 16'h0001,
  parameter int                    MAX_LEN    = 32,
  parameter int                    IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  replay,
  input  logic [SEED_WIDTH-1:0] seed_in,
  output logic                  load_seed,
  output logic                  busy,
  rng_seq_ctrl_if.master        cif
);

  localparam logic [IDX_WIDTH-1:0] MAX_IDX = IDX_WIDTH'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    RUN    = 2'd2,
    RELOAD = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [SEED_WIDTH-1:0] lfsr;
  logic [SEED_WIDTH-1:0] seed_save;
  logic [IDX_WIDTH-1:0]  color_idx;
  logic                  color_valid;
  logic                  seq_end;
  logic                  beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Outputs decode only from registered state/counters, never from inputs.
  always_comb begin
    state_n     = state;
    load_seed   = 1'b0;
    busy        = 1'b1;
    color_valid = 1'b0;
    seq_end     = 1'b0;
    case (state)
      IDLE: begin
        load_seed = 1'b1;
        busy      = 1'b0;
        if (start) state_n = SEED;
      end
      SEED:   state_n = RUN;
      RUN: begin
        color_valid = (color_idx < MAX_IDX);
        seq_end     = (color_idx == MAX_IDX);
        if (replay) state_n = RELOAD;
      end
      RELOAD: state_n = RUN;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  assign beat = color_valid & cif.color_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= '0;
      seed_save <= '0;
      color_idx <= '0;
    end else if (!abort) begin
      case (state)
        SEED: begin
          seed_save <= (seed_in == '0) ? ZERO_SEED : seed_in;
          lfsr      <= (seed_in == '0) ? ZERO_SEED : seed_in;
          color_idx <= '0;
        end
        RUN: begin
          // Replay wins over a coincident beat: that beat is neither counted nor stepped.
          if (!replay && beat) begin
            lfsr      <= lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
            color_idx <= color_idx + 1'b1;
          end
        end
        RELOAD: begin
          lfsr      <= seed_save;
          color_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign cif.color       = lfsr[1:0];
  assign cif.color_valid = color_valid;
  assign cif.color_idx   = color_idx;
  assign cif.seq_end     = seq_end;

endmodule

// File: tb/tb_rng_seq_ctrl.sv
// Directed bench for rng_seq_ctrl with a colour scoreboard fed from a reference LFSR.
module tb_rng_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        replay = 1'b0;
  logic [15:0] seed_in = 16'h0000;
  logic        load_seed;
  logic        busy;

  rng_seq_ctrl_if #(.IDX_WIDTH(8)) cif ();

  rng_seq_ctrl #(
    .SEED_WIDTH(16),
    .TAPS(16'hB400),
    .ZERO_SEED(16'h0001),
    .MAX_LEN(32),
    .IDX_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .replay(replay),
    .seed_in(seed_in),
    .load_seed(load_seed),
    .busy(busy),
    .cif(cif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] c;
    logic [7:0] idx;
  } exp_t;

  exp_t q[$];
  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned total    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic [15:0] r;
    r = {1'b0, v[15:1]};
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [15:0] ref_at(input logic [15:0] seed, input int unsigned k);
    logic [15:0] v;
    v = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int unsigned i = 0; i < k; i++) v = ref_step(v);
    return v;
  endfunction

  task automatic push_seq(input logic [15:0] seed, input int unsigned skip, input int unsigned n);
    logic [15:0] v;
    exp_t e;
    v = ref_at(seed, skip);
    for (int unsigned i = 0; i < n; i++) begin
      e.c   = v[1:0];
      e.idx = 8'(skip + i);
      q.push_back(e);
      v = ref_step(v);
    end
  endtask

  // Called at a negedge; consumes n beats with ready high, checking against the queue.
  task automatic beats(input int unsigned n);
    exp_t e;
    int   budget;
    cif.color_ready = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      budget = 20;
      while (!cif.color_valid && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (!cif.color_valid) begin
        chk("valid_timeout", 32'(cif.color_valid), 32'd1);
        break;
      end
      if (q.size() == 0) begin
        chk("queue_empty", 32'(q.size()), 32'd1);
        break;
      end
      e = q.pop_front();
      chk("beat_color", 32'(cif.color), 32'(e.c));
      chk("beat_idx", 32'(cif.color_idx), 32'(e.idx));
      @(negedge clk);
    end
    cif.color_ready = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] seed);
    seed_in = seed;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("seed_state", {29'd0, busy, load_seed, cif.color_valid}, {29'd0, 3'b100});
    @(negedge clk);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {29'd0, busy, load_seed, cif.color_valid}, {29'd0, 3'b010});
  endtask

  initial begin
    cif.color_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {20'd0, load_seed, busy, cif.color_valid, cif.seq_end, cif.color_idx},
        {20'd0, 4'b1000, 8'd0});
    chk("rst_color", 32'(cif.color), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", {29'd0, load_seed, busy, cif.color_valid}, {29'd0, 3'b100});
    end

    // Seed 0001: colours 1,0,0 from 0001 -> B400 -> 5A00
    do_start(16'h0001);
    chk("first_color", 32'(cif.color), 32'd1);
    chk("first_idx", 32'(cif.color_idx), 32'd0);
    push_seq(16'h0001, 0, 3);
    beats(3);
    do_abort();

    // Zero seed substitutes ZERO_SEED, then run to the MAX_LEN cap
    do_start(16'h0000);
    chk("zero_seed_color", 32'(cif.color), 32'd1);
    push_seq(16'h0000, 0, 32);
    beats(32);
    chk("end_state", {22'd0, cif.seq_end, cif.color_valid, cif.color_idx}, {22'd0, 2'b10, 8'd32});
    cif.color_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_idx", {22'd0, cif.seq_end, cif.color_valid, cif.color_idx}, {22'd0, 2'b10, 8'd32});
      chk("hold_color", 32'(cif.color), 32'(ref_at(16'h0000, 32) & 16'h0003));
    end
    cif.color_ready = 1'b0;

    // Replay from the ended state
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    chk("reload_state", {21'd0, busy, cif.seq_end, cif.color_valid, cif.color_idx},
        {21'd0, 3'b100, 8'd32});
    @(negedge clk);
    chk("replay_idx0", 32'(cif.color_idx), 32'd0);
    push_seq(16'h0000, 0, 5);
    beats(5);

    // Replay coincident with ready: beat dropped, same 5 colours repeat
    cif.color_ready = 1'b1;
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    cif.color_ready = 1'b0;
    chk("replay_drop", {23'd0, cif.color_valid, cif.color_idx}, {23'd0, 1'b0, 8'd5});
    @(negedge clk);
    chk("replay2_idx0", 32'(cif.color_idx), 32'd0);
    push_seq(16'h0000, 0, 5);
    beats(5);

    // Abort with simultaneous start, replay and ready
    cif.color_ready = 1'b1;
    start  = 1'b1;
    replay = 1'b1;
    do_abort();
    start  = 1'b0;
    replay = 1'b0;
    cif.color_ready = 1'b0;
    chk("abort_keep_idx", {23'd0, cif.seq_end, cif.color_idx}, {23'd0, 1'b0, 8'd5});
    chk("abort_keep_color", 32'(cif.color), 32'(ref_at(16'h0000, 5) & 16'h0003));
    @(negedge clk);
    chk("abort_stays_idle", {30'd0, busy, load_seed}, {30'd0, 2'b01});

    // Async reset mid-RUN
    do_start(16'hACE1);
    push_seq(16'hACE1, 0, 4);
    beats(4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {19'd0, load_seed, busy, cif.color_valid, cif.seq_end, cif.color, cif.color_idx},
        {19'd0, 4'b1000, 2'b00, 8'd0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(16'h1234);
    push_seq(16'h1234, 0, 3);
    beats(3);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total);
    $fatal(1);
  end

endmodule
